eu_icon_tx_arbiter: RTL and testbench
=====================================

Name: eu_icon_tx_arbiter

Overview:
Shares one execution unit's interconnect tx read port (address in, data/success out) between N_REQ remote requesters, typically the rx channels of other EUs.
- Round-robin arbitration.
- Registered issue and response stages.
- In-flight masking, so each requester has at most one outstanding read.
- Sits between the interconnect fabric and the EU's icon_tx_addr_i / icon_tx_req_valid_i / icon_tx_data_o / icon_tx_success_o pins.

Parameters:
N_REQ, 4, number of requesters (2..8)
PTR_W, $clog2(N_REQ), width of round-robin pointer and grant index (derived, not overridden)

Ports:
clk  in  1  clock
reset_n  in  1  reset; asynchronous, active-low
flush_i  in  1  synchronous flush of in-flight reads
req_valid_i  in  N_REQ  per-requester read request
req_addr_i  in  N_REQ*$bits(type_exec_unit_addr)  per-requester address, requester i at slice i
resp_valid_o  out  N_REQ  one-hot response strobe
resp_success_o  out  1  EU success flag for the current response
resp_data_o  out  $bits(type_exec_unit_data)  read data for the current response
eu_tx_addr_o  out  $bits(type_exec_unit_addr)  to EU icon_tx_addr_i
eu_tx_req_valid_o  out  1  to EU icon_tx_req_valid_i
eu_tx_data_i  in  $bits(type_exec_unit_data)  from EU icon_tx_data_o
eu_tx_success_i  in  1  from EU icon_tx_success_o
busy_o  out  1  any read in flight

Behaviour:
- Reset (async, reset_n=0) clears every output and state element to 0: rr_ptr=0, inflight mask=0, issue stage invalid, response stage invalid. resp_data_o=0, eu_tx_addr_o=0.
- Pipeline, for a request granted in cycle N:
  - A0 (cycle N): eligible = req_valid_i & ~inflight. Pick the first eligible index at or after rr_ptr, wrapping modulo N_REQ. On grant g:
    - register iss_valid=1, iss_idx=g, iss_addr=addr[g];
    - set inflight[g];
    - rr_ptr <= (g+1) mod N_REQ.
    - No grant means rr_ptr is unchanged.
  - I1 (cycle N+1): eu_tx_req_valid_o=iss_valid, eu_tx_addr_o=iss_addr. The EU answers combinationally in the same cycle. Register rsp_valid, rsp_idx, resp_data_o<=eu_tx_data_i, resp_success_o<=eu_tx_success_i.
  - R2 (cycle N+2): resp_valid_o = rsp_valid ? (1<<rsp_idx) : 0. Clear inflight[rsp_idx] at the end of R2.
- Latency: grant to response is 2 cycles. Throughput: 1 grant per cycle across distinct requesters. A single requester gets at most 1 grant per 3 cycles.
- Requester protocol: the address is sampled at grant only. Valid held high after resp_valid is treated as a new request from cycle N+3. A requester dropping valid while in flight still receives its response.
- Failure (eu_tx_success_i=0): returned as resp_success_o=0 with no automatic retry. resp_data_o carries whatever the EU drove.
- resp_data_o / resp_success_o hold their last value when resp_valid_o=0.
- Flush:
  - flush_i=1 clears iss_valid, rsp_valid and the inflight mask at the next edge.
  - No grant is made in a flush cycle; rr_ptr is held.
  - eu_tx_req_valid_o and resp_valid_o are 0 from the following cycle.
- busy_o = |inflight.
- req_valid_i=0 for all requesters: no state change except pipeline drain.

Decomposition:
- Reuse type_exec_unit_addr / type_exec_unit_data from pkg_dtypes.
- Add to pkg_dtypes: constant ICON_TX_ARB_NREQ=4 and typedef type_icon_tx_arb_idx (PTR_W bits).
- One sub-module: rr_arbiter (N_REQ-wide round-robin priority pick, combinational with pointer input, returns grant valid + index). Reusable for iqueue dispatch.

Test Plan:
- Single read: req0 valid, addr=0x12; EU returns data 0xBEEF, success=1 -> eu_tx_req_valid_o=1 with addr 0x12 at cycle 1; resp_valid_o=4'b0001, data 0xBEEF, success 1 at cycle 2.
- All four requesters valid at reset release -> grants in order 0,1,2,3 on consecutive cycles; resp_valid_o one-hot 0001,0010,0100,1000 at cycles 2..5.
- Requester 1 holds valid continuously, others idle -> grants at cycles 0,3,6; eu_tx_req_valid_o never twice in a row for idx 1.
- EU returns success=0 for addr 0x07 -> resp_success_o=0 with resp_valid_o asserted for that requester; the next request is unaffected.
- flush_i pulsed the cycle after grant to req2 -> no resp_valid_o for req2, busy_o=0 next cycle, and req2 is re-grantable immediately.
- Assert reset_n=0 mid-pipeline with 2 reads in flight -> all outputs 0 immediately; after release req0 is granted first.

Source files
------------

// File: rtl/pkg_dtypes.sv
`default_nettype none
//==============================================================================
// Package : pkg_dtypes
// Desc    : Shared EU datapath types and interconnect tx arbiter constants
// Rev     : 1.0
//==============================================================================
package pkg_dtypes;

    localparam int EXEC_UNIT_ADDR_W = 8;
    localparam int EXEC_UNIT_DATA_W = 16;

    typedef logic [EXEC_UNIT_ADDR_W-1:0] type_exec_unit_addr;
    typedef logic [EXEC_UNIT_DATA_W-1:0] type_exec_unit_data;

    localparam int ICON_TX_ARB_NREQ = 4;
    localparam int ICON_TX_ARB_PTR_W = (ICON_TX_ARB_NREQ > 1) ? $clog2(ICON_TX_ARB_NREQ) : 1;

    typedef logic [ICON_TX_ARB_PTR_W-1:0] type_icon_tx_arb_idx;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
//==============================================================================
// Module : rr_arbiter
// Desc   : Combinational round-robin pick: first set request at or after ptr
// Rev    : 1.0
//==============================================================================
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         gnt_valid,
    output logic [W-1:0] gnt_idx
);

    // Scan from the farthest offset down so the nearest hit to ptr wins last.
    always_comb begin : p_pick
        int j;
        j         = 0;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (req[j]) begin
                gnt_valid = 1'b1;
                gnt_idx   = W'(j);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/eu_icon_tx_arbiter.sv
`default_nettype none
//==============================================================================
// Module : eu_icon_tx_arbiter
// Desc   : Shares one EU interconnect tx read port among N_REQ requesters
// Rev    : 1.0
//==============================================================================
module eu_icon_tx_arbiter
    import pkg_dtypes::*;
#(
    parameter int N_REQ = ICON_TX_ARB_NREQ
) (
    input  logic                                         clk,
    input  logic                                         reset_n,
    input  logic                                         flush_i,
    input  logic [N_REQ-1:0]                             req_valid_i,
    input  logic [N_REQ*$bits(type_exec_unit_addr)-1:0]  req_addr_i,
    output logic [N_REQ-1:0]                             resp_valid_o,
    output logic                                         resp_success_o,
    output logic [$bits(type_exec_unit_data)-1:0]        resp_data_o,
    output logic [$bits(type_exec_unit_addr)-1:0]        eu_tx_addr_o,
    output logic                                         eu_tx_req_valid_o,
    input  logic [$bits(type_exec_unit_data)-1:0]        eu_tx_data_i,
    input  logic                                         eu_tx_success_i,
    output logic                                         busy_o
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int AW    = $bits(type_exec_unit_addr);

    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   gnt_idx;
    logic [PTR_W-1:0]   iss_idx;
    logic [PTR_W-1:0]   rsp_idx;
    logic [N_REQ-1:0]   inflight;
    logic [N_REQ-1:0]   eligible;
    logic [N_REQ-1:0]   gnt_onehot;
    logic [N_REQ-1:0]   rsp_onehot;
    logic               gnt_valid;
    logic               grant;
    logic               iss_valid;
    logic               rsp_valid;
    type_exec_unit_addr iss_addr;
    type_exec_unit_addr gnt_addr;

    assign eligible = req_valid_i & ~inflight;

    rr_arbiter #(
        .N (N_REQ),
        .W (PTR_W)
    ) u_rr_arbiter (
        .req       (eligible),
        .ptr       (rr_ptr),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    // A flush cycle never grants, so nothing new escapes the flush.
    assign grant      = gnt_valid & ~flush_i;
    assign gnt_addr   = req_addr_i[int'(gnt_idx)*AW +: AW];
    assign gnt_onehot = grant ? (N_REQ'(1) << gnt_idx) : '0;
    assign rsp_onehot = rsp_valid ? (N_REQ'(1) << rsp_idx) : '0;

    // A0: arbitration and issue register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr    <= '0;
            iss_valid <= 1'b0;
            iss_idx   <= '0;
            iss_addr  <= '0;
        end else if (flush_i) begin
            iss_valid <= 1'b0;
        end else begin
            iss_valid <= grant;
            if (grant) begin
                iss_idx  <= gnt_idx;
                iss_addr <= gnt_addr;
                rr_ptr   <= (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
            end
        end
    end

    // I1: EU answers combinationally; capture it only for a response that will be shown
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid      <= 1'b0;
            rsp_idx        <= '0;
            resp_data_o    <= '0;
            resp_success_o <= 1'b0;
        end else if (flush_i) begin
            rsp_valid <= 1'b0;
        end else begin
            rsp_valid <= iss_valid;
            if (iss_valid) begin
                rsp_idx        <= iss_idx;
                resp_data_o    <= eu_tx_data_i;
                resp_success_o <= eu_tx_success_i;
            end
        end
    end

    // Set and clear never hit the same bit: a requester is masked until its R2 ends.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inflight <= '0;
        end else if (flush_i) begin
            inflight <= '0;
        end else begin
            inflight <= (inflight & ~rsp_onehot) | gnt_onehot;
        end
    end

    assign eu_tx_req_valid_o = iss_valid;
    assign eu_tx_addr_o      = iss_addr;
    assign resp_valid_o      = rsp_onehot;
    assign busy_o            = |inflight;

endmodule
`default_nettype wire

// File: tb/tb_eu_icon_tx_arbiter.sv
`default_nettype none
// Bench for eu_icon_tx_arbiter: directed scenarios plus random traffic,
// all cycles checked against a timestamped transaction model.
module tb_eu_icon_tx_arbiter;
    import pkg_dtypes::*;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            flush_i = 1'b0;
    logic [N-1:0]    req_valid_i = '0;
    logic [N*AW-1:0] req_addr_i = '0;
    logic [N-1:0]    resp_valid_o;
    logic            resp_success_o;
    logic [DW-1:0]   resp_data_o;
    logic [AW-1:0]   eu_tx_addr_o;
    logic            eu_tx_req_valid_o;
    logic [DW-1:0]   eu_tx_data_i;
    logic            eu_tx_success_i;
    logic            busy_o;

    eu_icon_tx_arbiter #(.N_REQ(N)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .flush_i           (flush_i),
        .req_valid_i       (req_valid_i),
        .req_addr_i        (req_addr_i),
        .resp_valid_o      (resp_valid_o),
        .resp_success_o    (resp_success_o),
        .resp_data_o       (resp_data_o),
        .eu_tx_addr_o      (eu_tx_addr_o),
        .eu_tx_req_valid_o (eu_tx_req_valid_o),
        .eu_tx_data_i      (eu_tx_data_i),
        .eu_tx_success_i   (eu_tx_success_i),
        .busy_o            (busy_o)
    );

    always #5 clk = ~clk;

    // Execution-unit stand-in: fixed data/success per address
    function automatic logic [DW-1:0] eu_data(input logic [AW-1:0] a);
        if (a == 8'h12) return 16'hBEEF;
        return {a, a ^ 8'h5A};
    endfunction

    function automatic logic eu_succ(input logic [AW-1:0] a);
        return (a % 5) != 2;
    endfunction

    assign eu_tx_data_i    = eu_data(eu_tx_addr_o);
    assign eu_tx_success_i = eu_succ(eu_tx_addr_o);

    typedef struct {
        int          gc;
        int          idx;
        logic [7:0]  addr;
    } txn_t;

    txn_t        q[$];
    int          t;
    int          rr;
    logic [7:0]  m_addr;
    logic [15:0] m_data;
    logic        m_succ;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic model_reset();
        q.delete();
        rr     = 0;
        m_addr = '0;
        m_data = '0;
        m_succ = 1'b0;
        t      = 0;
    endtask

    task automatic set_addr(input int i, input logic [7:0] a);
        req_addr_i[i*AW +: AW] = a;
    endtask

    function automatic bit model_inflight(input int i);
        foreach (q[k]) if (q[k].idx == i) return 1'b1;
        return 1'b0;
    endfunction

    // One clock cycle: inputs already driven; check outputs, then advance the model.
    task automatic cycle();
        logic         exp_iv;
        logic [N-1:0] exp_rv;
        logic         exp_busy;
        int           g;
        int           i;
        #3;
        for (int k = q.size() - 1; k >= 0; k--) begin
            if (q[k].gc < t - 2) q.delete(k);
        end
        exp_iv = 1'b0;
        exp_rv = '0;
        foreach (q[k]) begin
            if (q[k].gc == t - 1) exp_iv = 1'b1;
            if (q[k].gc == t - 2) begin
                exp_rv[q[k].idx] = 1'b1;
                m_data = eu_data(q[k].addr);
                m_succ = eu_succ(q[k].addr);
            end
        end
        exp_busy = (q.size() != 0);

        n_cmp++;
        if (eu_tx_req_valid_o !== exp_iv) begin
            n_err++;
            $display("FAIL eu_tx_req_valid t=%0d: got %b want %b", t, eu_tx_req_valid_o, exp_iv);
        end
        n_cmp++;
        if (eu_tx_addr_o !== m_addr) begin
            n_err++;
            $display("FAIL eu_tx_addr t=%0d: got %h want %h", t, eu_tx_addr_o, m_addr);
        end
        n_cmp++;
        if (resp_valid_o !== exp_rv) begin
            n_err++;
            $display("FAIL resp_valid t=%0d: got %b want %b", t, resp_valid_o, exp_rv);
        end
        n_cmp++;
        if (resp_data_o !== m_data) begin
            n_err++;
            $display("FAIL resp_data t=%0d: got %h want %h", t, resp_data_o, m_data);
        end
        n_cmp++;
        if (resp_success_o !== m_succ) begin
            n_err++;
            $display("FAIL resp_success t=%0d: got %b want %b", t, resp_success_o, m_succ);
        end
        n_cmp++;
        if (busy_o !== exp_busy) begin
            n_err++;
            $display("FAIL busy t=%0d: got %b want %b", t, busy_o, exp_busy);
        end

        if (flush_i) begin
            q.delete();
        end else begin
            g = -1;
            for (int k = 0; k < N; k++) begin
                i = (rr + k) % N;
                if (g < 0 && req_valid_i[i] && !model_inflight(i)) g = i;
            end
            if (g >= 0) begin
                q.push_back('{gc: t, idx: g, addr: req_addr_i[g*AW +: AW]});
                m_addr = req_addr_i[g*AW +: AW];
                rr     = (g + 1) % N;
            end
        end
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        flush_i     = 1'b0;
        req_valid_i = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic drain(input int n);
        req_valid_i = '0;
        flush_i     = 1'b0;
        repeat (n) cycle();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #2;
        n_cmp++;
        if ({resp_valid_o, resp_success_o, resp_data_o, eu_tx_addr_o, eu_tx_req_valid_o, busy_o} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b %b %h %h %b %b want all zero", resp_valid_o,
                     resp_success_o, resp_data_o, eu_tx_addr_o, eu_tx_req_valid_o, busy_o);
        end
        do_reset();
    endtask

    task automatic test_single_read();
        do_reset();
        set_addr(0, 8'h12);
        req_valid_i = 4'b0001;
        cycle();
        req_valid_i = '0;
        n_cmp++;
        if (eu_tx_req_valid_o !== 1'b1 || eu_tx_addr_o !== 8'h12) begin
            n_err++;
            $display("FAIL single_issue: got v=%b a=%h want v=1 a=12", eu_tx_req_valid_o, eu_tx_addr_o);
        end
        cycle();
        n_cmp++;
        if (resp_valid_o !== 4'b0001 || resp_data_o !== 16'hBEEF || resp_success_o !== 1'b1) begin
            n_err++;
            $display("FAIL single_resp: got v=%b d=%h s=%b want v=0001 d=beef s=1",
                     resp_valid_o, resp_data_o, resp_success_o);
        end
        drain(3);
    endtask

    task automatic test_all_four();
        do_reset();
        for (int k = 0; k < N; k++) set_addr(k, 8'($urandom));
        req_valid_i = 4'hF;
        for (int c = 0; c < 6; c++) begin
            if (c >= 2) begin
                n_cmp++;
                if (resp_valid_o !== 4'(1 << (c - 2))) begin
                    n_err++;
                    $display("FAIL all_four_order c=%0d: got %b want %b", c, resp_valid_o, 4'(1 << (c - 2)));
                end
            end
            if (c == 4) req_valid_i = '0;
            cycle();
        end
        drain(3);
    endtask

    task automatic test_single_hog();
        do_reset();
        set_addr(1, 8'h3C);
        req_valid_i = 4'b0010;
        for (int c = 0; c < 9; c++) begin
            n_cmp++;
            if (eu_tx_req_valid_o !== ((c % 3) == 1)) begin
                n_err++;
                $display("FAIL hog_spacing c=%0d: got %b want %b", c, eu_tx_req_valid_o, (c % 3) == 1);
            end
            cycle();
        end
        drain(3);
    endtask

    task automatic test_failure();
        do_reset();
        set_addr(2, 8'h07);
        set_addr(3, 8'h21);
        req_valid_i = 4'b0100;
        cycle();
        req_valid_i = 4'b1000;
        cycle();
        req_valid_i = '0;
        n_cmp++;
        if (resp_valid_o !== 4'b0100 || resp_success_o !== 1'b0 || resp_data_o !== 16'h075D) begin
            n_err++;
            $display("FAIL fail_resp: got v=%b s=%b d=%h want v=0100 s=0 d=075d",
                     resp_valid_o, resp_success_o, resp_data_o);
        end
        cycle();
        n_cmp++;
        if (resp_valid_o !== 4'b1000 || resp_success_o !== 1'b1 || resp_data_o !== 16'h217B) begin
            n_err++;
            $display("FAIL after_fail_resp: got v=%b s=%b d=%h want v=1000 s=1 d=217b",
                     resp_valid_o, resp_success_o, resp_data_o);
        end
        drain(3);
    endtask

    task automatic test_flush();
        do_reset();
        set_addr(2, 8'h33);
        req_valid_i = 4'b0100;
        cycle();
        flush_i = 1'b1;
        cycle();
        flush_i = 1'b0;
        n_cmp++;
        if (busy_o !== 1'b0 || resp_valid_o !== 4'b0000 || eu_tx_req_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL flush_clear: got busy=%b rv=%b iv=%b want 0 0000 0",
                     busy_o, resp_valid_o, eu_tx_req_valid_o);
        end
        cycle();
        n_cmp++;
        if (eu_tx_req_valid_o !== 1'b1 || eu_tx_addr_o !== 8'h33) begin
            n_err++;
            $display("FAIL flush_regrant: got v=%b a=%h want v=1 a=33", eu_tx_req_valid_o, eu_tx_addr_o);
        end
        req_valid_i = '0;
        cycle();
        n_cmp++;
        if (resp_valid_o !== 4'b0100) begin
            n_err++;
            $display("FAIL flush_regrant_resp: got %b want 0100", resp_valid_o);
        end
        drain(3);
    endtask

    task automatic test_reset_mid_pipeline();
        do_reset();
        set_addr(0, 8'h41);
        set_addr(1, 8'h42);
        req_valid_i = 4'b0011;
        cycle();
        cycle();
        req_valid_i = '0;
        #1;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({resp_valid_o, resp_success_o, resp_data_o, eu_tx_addr_o, eu_tx_req_valid_o, busy_o} !== '0) begin
            n_err++;
            $display("FAIL async_reset: got %b %b %h %h %b %b want all zero", resp_valid_o,
                     resp_success_o, resp_data_o, eu_tx_addr_o, eu_tx_req_valid_o, busy_o);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        for (int k = 0; k < N; k++) set_addr(k, 8'h50 + 8'(k));
        req_valid_i = 4'hF;
        cycle();
        req_valid_i = '0;
        n_cmp++;
        if (eu_tx_req_valid_o !== 1'b1 || eu_tx_addr_o !== 8'h50) begin
            n_err++;
            $display("FAIL post_reset_first: got v=%b a=%h want v=1 a=50", eu_tx_req_valid_o, eu_tx_addr_o);
        end
        drain(3);
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            req_valid_i = 4'($urandom);
            for (int k = 0; k < N; k++) set_addr(k, 8'($urandom));
            flush_i = ($urandom_range(0, 19) == 0);
            cycle();
        end
        drain(4);
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_all_four();
        test_single_hog();
        test_failure();
        test_flush();
        test_reset_mid_pipeline();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
